// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP image pipeline.
//   GRAY_AW / GRAY_DW / IMG_W : gray image memory geometry (128x128, 8-bit pixels)
//   arb_state_e               : gray memory arbiter states
//   REQ_LBP / REQ_AUX         : requester ids carried with each memory read
package lbp_pkg;

    localparam int unsigned GRAY_AW = 14;
    localparam int unsigned GRAY_DW = 8;
    localparam int unsigned IMG_W   = 128;

    typedef enum logic [1:0] {
        WAIT_RDY,
        ARB,
        LOCK0,
        LOCK1
    } arb_state_e;

    localparam logic REQ_LBP = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Reset-clearable shift register that carries {valid, id} tags alongside
// in-flight memory reads, so returned data can be routed to its requester.
//   clk   : clock
//   reset : asynchronous, active-high; clears every stage
//   din   : tag entering the pipe this cycle
//   dout  : tag leaving the pipe (DEPTH cycles after entry)
module rd_tag_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gray_mem_arbiter.sv
// Shares the single-port gray image memory between two read requesters
// (port 0 = LBP engine, port 1 = auxiliary reader). Round-robin arbitration,
// optional burst lock with a starvation limit, and owner tags that follow
// each read through the memory latency.
//   clk, reset           : clock, asynchronous active-high reset
//   gray_ready           : memory loaded; grants start only after it is seen
//   gray_req, gray_addr  : registered memory read strobe / address
//   gray_data            : memory read data, RD_LAT cycles after gray_req
//   rN_req/addr/lock     : requester N read request, address, burst lock
//   rN_gnt               : combinational grant (request accepted this cycle)
//   rN_rvalid, rN_rdata  : returned data for requester N
module gray_mem_arbiter
    import lbp_pkg::*;
#(
    parameter int unsigned AW        = GRAY_AW,
    parameter int unsigned DW        = GRAY_DW,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic          r0_lock,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic          r1_lock,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata
);

    localparam int unsigned   CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    arb_state_e    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          gray_req_q;
    logic [AW-1:0] gray_addr_q;
    logic          gray_id_q;

    logic          win;
    logic          lock_owner;
    logic          own_req;
    logic          own_lock;
    logic          oth_req;
    logic          gnt_any;
    logic [1:0]    tag_out;

    // Owner-relative view of the requesters while a burst lock is held.
    assign lock_owner = (state_q == LOCK1);
    assign own_req    = lock_owner ? r1_req  : r0_req;
    assign own_lock   = lock_owner ? r1_lock : r0_lock;
    assign oth_req    = lock_owner ? r0_req  : r1_req;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        win         = 1'b0;

        unique case (state_q)
            WAIT_RDY: begin
                if (gray_ready) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (r0_req || r1_req) begin
                    win      = (r0_req && r1_req) ? rr_ptr_q : r1_req;
                    r0_gnt   = ~win;
                    r1_gnt   = win;
                    rr_ptr_d = ~win;
                    if (win ? r1_lock : r0_lock) begin
                        state_d     = win ? LOCK1 : LOCK0;
                        burst_cnt_d = CW'(1);
                    end
                end
            end

            LOCK0, LOCK1: begin
                if (!own_req) begin
                    state_d     = ARB;
                    burst_cnt_d = '0;
                end else if (burst_cnt_q >= BURST_MAX && oth_req) begin
                    // Starvation limit: yield without granting; rr_ptr already
                    // points at the other port, so it wins the next ARB cycle.
                    state_d     = ARB;
                    burst_cnt_d = '0;
                end else begin
                    r0_gnt = ~lock_owner;
                    r1_gnt = lock_owner;
                    if (burst_cnt_q < BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                    if (!own_lock) begin
                        state_d     = ARB;
                        burst_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = WAIT_RDY;
            end
        endcase
    end

    assign gnt_any = r0_gnt | r1_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_RDY;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            gray_id_q   <= REQ_LBP;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gray_req_q  <= gnt_any;
            if (gnt_any) begin
                gray_addr_q <= r1_gnt ? r1_addr : r0_addr;
                gray_id_q   <= r1_gnt ? REQ_AUX : REQ_LBP;
            end
        end
    end

    assign gray_req  = gray_req_q;
    assign gray_addr = gray_addr_q;

    // Tags enter alongside the registered strobe, so they exit exactly when
    // the memory presents the matching data.
    rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (2)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .din   ({gray_req_q, gray_id_q}),
        .dout  (tag_out)
    );

    assign r0_rvalid = tag_out[1] & (tag_out[0] == REQ_LBP);
    assign r1_rvalid = tag_out[1] & (tag_out[0] == REQ_AUX);
    assign r0_rdata  = gray_data;
    assign r1_rdata  = gray_data;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Directed bench for gray_mem_arbiter. Two instances share the requester
// inputs: dut_a (RD_LAT=1, MAX_BURST=9) and dut_b (RD_LAT=3, MAX_BURST=4).
// Each has its own memory model whose pixel value is pix(addr).
module tb_gray_mem_arbiter;
    import lbp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        r0_req, r0_lock, r1_req, r1_lock;
    logic [13:0] r0_addr, r1_addr;

    logic        a_gray_req, a_r0_gnt, a_r0_rvalid, a_r1_gnt, a_r1_rvalid;
    logic [13:0] a_gray_addr;
    logic [7:0]  a_gray_data, a_r0_rdata, a_r1_rdata;
    logic        b_gray_req, b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid;
    logic [13:0] b_gray_addr;
    logic [7:0]  b_gray_data, b_r0_rdata, b_r1_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [13:0] a);
        return a[7:0] + {2'b00, a[13:8]} + 8'h5A;
    endfunction

    // Memory models: address sampled at posedge, data after RD_LAT cycles.
    logic [13:0] a_lat;
    logic [13:0] b_lat [3];
    always @(posedge clk) begin
        a_lat    <= a_gray_addr;
        b_lat[0] <= b_gray_addr;
        b_lat[1] <= b_lat[0];
        b_lat[2] <= b_lat[1];
    end
    assign a_gray_data = pix(a_lat);
    assign b_gray_data = pix(b_lat[2]);

    gray_mem_arbiter #(
        .AW (14), .DW (8), .RD_LAT (1), .MAX_BURST (9)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (a_gray_req),
        .gray_addr  (a_gray_addr),
        .gray_data  (a_gray_data),
        .r0_req     (r0_req),
        .r0_addr    (r0_addr),
        .r0_lock    (r0_lock),
        .r0_gnt     (a_r0_gnt),
        .r0_rvalid  (a_r0_rvalid),
        .r0_rdata   (a_r0_rdata),
        .r1_req     (r1_req),
        .r1_addr    (r1_addr),
        .r1_lock    (r1_lock),
        .r1_gnt     (a_r1_gnt),
        .r1_rvalid  (a_r1_rvalid),
        .r1_rdata   (a_r1_rdata)
    );

    gray_mem_arbiter #(
        .AW (14), .DW (8), .RD_LAT (3), .MAX_BURST (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (b_gray_req),
        .gray_addr  (b_gray_addr),
        .gray_data  (b_gray_data),
        .r0_req     (r0_req),
        .r0_addr    (r0_addr),
        .r0_lock    (r0_lock),
        .r0_gnt     (b_r0_gnt),
        .r0_rvalid  (b_r0_rvalid),
        .r0_rdata   (b_r0_rdata),
        .r1_req     (r1_req),
        .r1_addr    (r1_addr),
        .r1_lock    (r1_lock),
        .r1_gnt     (b_r1_gnt),
        .r1_rvalid  (b_r1_rvalid),
        .r1_rdata   (b_r1_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        r0_req  = 1'b0;
        r0_lock = 1'b0;
        r0_addr = '0;
        r1_req  = 1'b0;
        r1_lock = 1'b0;
        r1_addr = '0;
    endtask

    // Leaves the DUTs in the first cycle after reset (ARB if gray_ready=1).
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
    endtask

    logic [13:0] t3_addr [10];
    logic [11:0] t4_e0;
    logic [11:0] t4_e1;
    int          rv_cnt;

    initial begin
        t3_addr = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130,
                    14'd256, 14'd257, 14'd258, 14'd259};
        t4_e0   = 12'b0011_1100_1111;
        t4_e1   = 12'b1000_0010_0000;
        gray_ready = 1'b0;
        clear_inputs();

        // Reset state, with a request pending.
        reset  = 1'b1;
        r0_req = 1'b1;
        tick();
        #1;
        chk("rst_gray_req",  32'(a_gray_req),  32'h0);
        chk("rst_gray_addr", 32'(a_gray_addr), 32'h0);
        chk("rst_r0_gnt",    32'(a_r0_gnt),    32'h0);
        chk("rst_r0_rvalid", 32'(a_r0_rvalid), 32'h0);
        chk("rst_r1_rvalid", 32'(a_r1_rvalid), 32'h0);

        // T1: no grant before gray_ready.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            r0_req  = 1'b1;
            r0_addr = 14'd5;
            #1;
            chk("t1_wait_gnt", 32'(a_r0_gnt),   32'h0);
            chk("t1_wait_req", 32'(a_gray_req), 32'h0);
            tick();
        end
        gray_ready = 1'b1;
        #1;
        chk("t1_ready_cycle_gnt", 32'(a_r0_gnt), 32'h0);
        tick();
        #1;
        chk("t1_first_gnt", 32'(a_r0_gnt), 32'h1);
        tick();
        r0_req = 1'b0;
        #1;
        chk("t1_gray_req",  32'(a_gray_req),  32'h1);
        chk("t1_gray_addr", 32'(a_gray_addr), 32'h5);
        tick();
        #1;
        chk("t1_r0_rvalid", 32'(a_r0_rvalid), 32'h1);
        chk("t1_r1_rvalid", 32'(a_r1_rvalid), 32'h0);
        chk("t1_r0_rdata",  32'(a_r0_rdata),  32'h5F);

        // T2: alternation, data routed to the issuing port.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            r0_req  = (c < 4);
            r0_addr = 14'h0000;
            r1_req  = (c < 4);
            r1_addr = 14'h3FFF;
            #1;
            if (c < 4) begin
                chk("t2_r0_gnt", 32'(a_r0_gnt), 32'(c % 2 == 0));
                chk("t2_r1_gnt", 32'(a_r1_gnt), 32'(c % 2 == 1));
            end
            if (c >= 2) begin
                chk("t2_r0_rvalid", 32'(a_r0_rvalid), 32'(c % 2 == 0));
                chk("t2_r1_rvalid", 32'(a_r1_rvalid), 32'(c % 2 == 1));
                if (c % 2 == 0) chk("t2_r0_rdata", 32'(a_r0_rdata), 32'h5A);
                else            chk("t2_r1_rdata", 32'(a_r1_rdata), 32'h98);
            end
            tick();
        end

        // T3: r0 locked burst on dut_a (MAX_BURST=9), r1 arrives at beat 2.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            r0_req  = 1'b1;
            r0_lock = 1'b1;
            r0_addr = (c <= 9) ? t3_addr[c] : t3_addr[9];
            r1_req  = (c >= 1);
            r1_addr = 14'h0777;
            #1;
            chk("t3_r0_gnt", 32'(a_r0_gnt), 32'(c <= 8));
            chk("t3_r1_gnt", 32'(a_r1_gnt), 32'(c == 10));
            if (c >= 1 && c <= 9) chk("t3_gray_addr", 32'(a_gray_addr), 32'(t3_addr[c-1]));
            if (c == 10) chk("t3_idle_gray_req", 32'(a_gray_req), 32'h0);
            tick();
        end
        clear_inputs();

        // T4: starvation limit on dut_b (MAX_BURST=4), r0 locked forever.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            r0_req  = 1'b1;
            r0_lock = 1'b1;
            r0_addr = 14'd10;
            r1_req  = 1'b1;
            r1_addr = 14'h1234;
            #1;
            chk("t4_r0_gnt", 32'(b_r0_gnt), 32'(t4_e0[c]));
            chk("t4_r1_gnt", 32'(b_r1_gnt), 32'(t4_e1[c]));
            tick();
        end
        clear_inputs();

        // T5: reset one cycle after a grant drops the in-flight read (dut_b).
        do_reset();
        r1_req  = 1'b1;
        r1_addr = 14'h0100;
        #1;
        chk("t5_r1_gnt", 32'(b_r1_gnt), 32'h1);
        tick();
        r1_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("t5_gray_req", 32'(b_gray_req), 32'h0);
        chk("t5_state", 32'(dut_b.state_q), 32'(WAIT_RDY));
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t5_r0_rvalid", 32'(b_r0_rvalid), 32'h0);
            chk("t5_r1_rvalid", 32'(b_r1_rvalid), 32'h0);
            tick();
        end

        // T6: RD_LAT=3 streaming, r1 reads 100..119 back to back.
        do_reset();
        rv_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            r1_req  = (c < 20);
            r1_addr = 14'(100 + c);
            #1;
            if (c < 20) chk("t6_r1_gnt", 32'(b_r1_gnt), 32'h1);
            chk("t6_r1_rvalid", 32'(b_r1_rvalid), 32'(c >= 4 && c < 24));
            if (b_r1_rvalid) rv_cnt++;
            if (c >= 4 && c < 24) chk("t6_r1_rdata", 32'(b_r1_rdata), 32'(pix(14'(96 + c))));
            tick();
        end
        chk("t6_rvalid_count", 32'(rv_cnt), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
